// File: rtl/servo_pos_ctrl.sv
// servo_pos_ctrl: command stage in front of the servo PWM generator.
// Synchronises and debounces the raw active-low button, steps a position
// index through NUM_POS positions with wrap-around (auto-repeat while held),
// and commits the matching PWM high time only at a PWM frame boundary.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   boton_n     raw button, active-low, asynchronous, bouncy
//   frame_start one-cycle pulse at the start of each PWM frame
//   pulse_width committed PWM high time in clk cycles
//   pos_idx     committed position index
//   step_pulse  one-cycle pulse on each accepted step (press or repeat)
//   pw_update   one-cycle pulse in the cycle pulse_width changes
module servo_pos_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int NUM_POS      = 3,
  parameter int MIN_PW       = 50_000,
  parameter int STEP_PW      = 25_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boton_n,
  input  logic        frame_start,
  output logic [19:0] pulse_width,
  output logic [3:0]  pos_idx,
  output logic        step_pulse,
  output logic        pw_update
);

  localparam logic [24:0] DEB_TERM  = 25'(DEBOUNCE_CYC - 1);
  localparam logic [24:0] HOLD_TERM = 25'(HOLD_CYC - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_POS - 1);
  localparam logic [19:0] MIN_W     = 20'(MIN_PW);
  localparam logic [19:0] STEP_W    = 20'(STEP_PW);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HELD, S_REL} state_t;

  state_t      r_state, w_state_nxt;
  logic [24:0] r_cnt, w_cnt_nxt;
  logic        r_sync1, r_sync2;
  logic        w_btn;
  logic        w_step;
  logic [3:0]  r_pend_idx, w_next_idx;
  logic        r_pend;
  logic        w_commit;
  logic [19:0] w_next_pw;
  logic [19:0] r_pw;
  logic [3:0]  r_pos;
  logic        r_upd;

  // Synchroniser flops reset to 1 so the button reads as released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= boton_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn = ~r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 25'd1;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_btn) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (!w_btn) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_TERM) begin
          w_state_nxt = S_HELD;
          w_step      = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      S_HELD: begin
        if (!w_btn) begin
          w_state_nxt = S_REL;
          w_cnt_nxt   = '0;
        end else if (r_cnt == HOLD_TERM) begin
          w_step    = 1'b1;
          w_cnt_nxt = '0;
        end
      end
      S_REL: begin
        // A bounce back to pressed resumes holding without a new step.
        if (w_btn) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_TERM) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The index that will be pending after this edge; a step firing in a
  // frame_start cycle is folded into that same commit.
  always_comb begin
    w_next_idx = r_pend_idx;
    if (w_step) w_next_idx = (r_pend_idx == LAST_IDX) ? '0 : r_pend_idx + 4'd1;
    w_commit  = frame_start & (r_pend | w_step);
    w_next_pw = MIN_W + STEP_W * {16'd0, w_next_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_idx <= '0;
      r_pend     <= 1'b0;
      r_pos      <= '0;
      r_pw       <= MIN_W;
      r_upd      <= 1'b0;
    end else begin
      r_upd      <= 1'b0;
      r_pend_idx <= w_next_idx;
      if (w_commit) begin
        r_pos  <= w_next_idx;
        r_pw   <= w_next_pw;
        r_upd  <= (w_next_pw != r_pw);
        r_pend <= 1'b0;
      end else if (w_step) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign pulse_width = r_pw;
  assign pos_idx     = r_pos;
  assign step_pulse  = w_step;
  assign pw_update   = r_upd;

endmodule

// File: tb/tb_servo_pos_ctrl.sv
// tb_servo_pos_ctrl: self-checking bench for servo_pos_ctrl with small
// timing parameters. A run-length based reference model checks every cycle;
// a segment table and a few hand sequences check the headline behaviours.
module tb_servo_pos_ctrl;

  localparam int D    = 8;
  localparam int H    = 40;
  localparam int N    = 3;
  localparam int MINW = 100;
  localparam int STPW = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boton_n = 1'b1;
  logic        frame_start = 1'b0;
  logic [19:0] pulse_width;
  logic [3:0]  pos_idx;
  logic        step_pulse;
  logic        pw_update;

  servo_pos_ctrl #(
    .DEBOUNCE_CYC(D),
    .HOLD_CYC(H),
    .NUM_POS(N),
    .MIN_PW(MINW),
    .STEP_PW(STPW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .boton_n(boton_n),
    .frame_start(frame_start),
    .pulse_width(pulse_width),
    .pos_idx(pos_idx),
    .step_pulse(step_pulse),
    .pw_update(pw_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: button seen two cycles late; a level is accepted once it
  // has persisted D+1 consecutive cycles; repeats every H cycles while held.
  bit mvalid = 1'b0;
  bit bq[$];
  int m_run, m_hs, m_now;
  bit m_prev, m_acc;
  int m_pidx, m_pos, m_pw;
  bit m_pend, m_upd;

  task automatic tick(output bit st);
    bit btn, ms;
    int npw;
    @(negedge clk);
    st = step_pulse;
    if (mvalid) begin
      chk("pos_idx", {28'd0, pos_idx}, m_pos);
      chk("pulse_width", {12'd0, pulse_width}, m_pw);
      chk("pw_update", {31'd0, pw_update}, {31'd0, m_upd});
    end
    if (rst) begin
      mvalid = 1'b1;
      bq = {1'b0, 1'b0};
      m_run = 0; m_hs = 0; m_now = 0; m_prev = 1'b0; m_acc = 1'b0;
      m_pidx = 0; m_pend = 1'b0; m_pos = 0; m_pw = MINW; m_upd = 1'b0;
    end else if (mvalid) begin
      btn = bq[0];
      m_run = (btn == m_prev) ? m_run + 1 : 1;
      ms = 1'b0;
      if (!m_acc) begin
        if (btn && m_run == D + 1) begin
          ms = 1'b1; m_acc = 1'b1; m_hs = m_now;
        end
      end else if (btn) begin
        if (!m_prev) m_hs = m_now;
        else if (m_now - m_hs == H) begin
          ms = 1'b1; m_hs = m_now;
        end
      end else if (m_run == D + 1) begin
        m_acc = 1'b0;
      end
      m_prev = btn;
      chk("step_pulse", {31'd0, step_pulse}, {31'd0, ms});
      m_upd = 1'b0;
      if (ms) m_pidx = (m_pidx + 1) % N;
      if (frame_start && (m_pend || ms)) begin
        npw = MINW + STPW * m_pidx;
        m_upd = (npw != m_pw);
        m_pw = npw;
        m_pos = m_pidx;
        m_pend = 1'b0;
      end else if (ms) begin
        m_pend = 1'b1;
      end
      void'(bq.pop_front());
      bq.push_back(!boton_n);
      m_now++;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r;
    bit bn;
    bit fs;
    int cyc;
    int steps;
    int pos;
    int pw;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit bn, input bit fs, input int cyc,
                     input int steps, input int pos, input int pw);
    vec_t v;
    v.r = r; v.bn = bn; v.fs = fs; v.cyc = cyc;
    v.steps = steps; v.pos = pos; v.pw = pw;
    tbl.push_back(v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    int stc;
    int lat;

    // Segments: {rst, boton_n, frame_start on first cycle, cycles, steps, pos, pw}
    add(1, 1, 0, 2, 0, 0, 100);      // reset state
    add(0, 0, 0, 20, 1, 0, 100);     // single press
    add(0, 1, 0, 30, 0, 0, 100);     // release
    add(0, 1, 1, 3, 0, 1, 150);      // commit at frame
    for (int i = 0; i < 10; i++) add(0, (i % 2) == 1, 0, 3, 0, 1, 150);  // bounce
    add(0, 1, 0, 20, 0, 1, 150);
    add(0, 1, 1, 2, 0, 1, 150);      // frame with nothing pending
    add(0, 0, 0, 150, 4, 1, 150);    // hold: 4 steps, 1 -> 2
    add(0, 1, 0, 20, 0, 1, 150);
    add(0, 1, 1, 2, 0, 2, 200);
    add(0, 0, 0, 100, 3, 2, 200);    // 3 steps wrap back to 2
    add(0, 1, 0, 20, 0, 2, 200);
    add(0, 1, 1, 2, 0, 2, 200);      // unchanged width
    add(0, 0, 0, 30, 1, 2, 200);     // into HELD
    add(1, 0, 0, 1, 0, 0, 100);      // reset while held
    add(0, 0, 0, 10, 0, 0, 100);     // full debounce needed again
    add(0, 0, 0, 1, 1, 0, 100);
    add(0, 1, 0, 20, 0, 0, 100);
    add(0, 1, 1, 2, 0, 1, 150);

    foreach (tbl[k]) begin
      stc = 0;
      for (int c = 0; c < tbl[k].cyc; c++) begin
        rst = tbl[k].r;
        boton_n = tbl[k].bn;
        frame_start = tbl[k].fs && (c == 0);
        tick(st);
        if (st && !rst) stc++;
      end
      chk($sformatf("vec%0d_steps", k), stc, tbl[k].steps);
      chk($sformatf("vec%0d_pos", k), {28'd0, pos_idx}, tbl[k].pos);
      chk($sformatf("vec%0d_pw", k), {12'd0, pulse_width}, tbl[k].pw);
    end

    // Randomised segments against the model.
    rst = 1'b0;
    for (int s = 0; s < 80; s++) begin
      int len;
      bit lvl;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 110);
      for (int c = 0; c < len; c++) begin
        boton_n = lvl;
        frame_start = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 999) == 0);
        tick(st);
      end
    end
    rst = 1'b0;
    frame_start = 1'b0;

    // Press-to-step latency is 2 + D cycles.
    boton_n = 1'b1;
    rst = 1'b1;
    tick(st);
    rst = 1'b0;
    boton_n = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      tick(st);
      if (st) begin
        lat = i;
        break;
      end
    end
    chk("press_latency", lat, 2 + D);

    // Step in the same cycle as frame_start is committed at that frame.
    boton_n = 1'b1;
    rst = 1'b1;
    tick(st);
    rst = 1'b0;
    boton_n = 1'b0;
    for (int i = 0; i < 10; i++) tick(st);
    frame_start = 1'b1;
    tick(st);
    chk("simul_step", {31'd0, st}, 1);
    frame_start = 1'b0;
    chk("simul_pos", {28'd0, pos_idx}, 1);
    chk("simul_pw", {12'd0, pulse_width}, 150);
    chk("simul_upd", {31'd0, pw_update}, 1);
    tick(st);
    chk("simul_upd_clear", {31'd0, pw_update}, 0);

    boton_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(st);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pos_ctrl.md
Name: servo_pos_ctrl

Overview:
Upstream command stage for the servo PWM generator. It synchronises and debounces the raw active-low push-button, then steps a position index through NUM_POS positions with wrap-around, auto-repeating while the button is held. It outputs the PWM high time in clock cycles. The new width is committed only at a PWM frame boundary, so the downstream generator never sees a mid-frame change.

Parameters:
DEBOUNCE_CYC, 1_000_000, cycles the synced input must stay stable to be accepted (20 ms at 50 MHz)
HOLD_CYC, 25_000_000, auto-repeat interval while held (0.5 s); first repeat fires HOLD_CYC after the accepted press
NUM_POS, 3, number of positions (2..16)
MIN_PW, 50_000, high time for index 0 (1 ms)
STEP_PW, 25_000, high-time increment per index (0.5 ms)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
boton_n  input  1  raw button, active-low, asynchronous, bouncy
frame_start  input  1  one-cycle pulse from the PWM stage at the start of each 20 ms frame
pulse_width  output  20  committed PWM high time in clk cycles
pos_idx  output  4  committed position index
step_pulse  output  1  one-cycle pulse on each accepted step (press or repeat)
pw_update  output  1  one-cycle pulse in the cycle pulse_width changes

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: pulse_width=MIN_PW, pos_idx=0, step_pulse=0, pw_update=0.
  - Internal state: pending index=0, pending flag=0, FSM=IDLE, counters=0, synchroniser flops=1 (released).
  - Reset mid-debounce or mid-hold discards all progress.
- Synchroniser:
  - 2-FF chain on boton_n; btn = inverted output of the second flop.
  - Two-cycle input latency.
- FSM states:
  - IDLE: btn=1 → ARM, cnt=0.
  - ARM: btn=0 → IDLE. Otherwise cnt++; when cnt reaches DEBOUNCE_CYC-1 → HELD, fire step, cnt=0.
  - HELD: btn=0 → REL, cnt=0. Otherwise cnt++; when cnt reaches HOLD_CYC-1 → fire step, cnt=0, stay in HELD.
  - REL: btn=1 → HELD, cnt=0, no step. Otherwise cnt++; when cnt reaches DEBOUNCE_CYC-1 → IDLE.
- Step:
  - step_pulse=1 for one cycle.
  - Pending index += 1; wraps NUM_POS-1 → 0.
  - Pending flag set.
- Commit:
  - Triggered in the cycle frame_start=1 with pending flag set, or with a step firing in that same cycle. The simultaneous step is included in the commit.
  - At the next edge: pos_idx ← pending index; pulse_width ← MIN_PW + STEP_PW*index; pending flag cleared.
  - pw_update=1 only if pulse_width actually changes. A wrap back to the same index gives no pulse.
- Multiple steps between frames: only the latest index is committed; intermediate positions are skipped.
- frame_start with nothing pending: no output change.
- Arithmetic: pulse_width computed in 20 bits. Caller guarantees MIN_PW + STEP_PW*(NUM_POS-1) < 2^20. No saturation.
- Counters: 25 bits. Terminal compare is equality; counters never wrap past terminal.
- Latency:
  - Raw press to step_pulse = 2 + DEBOUNCE_CYC cycles.
  - Step to pulse_width change = waiting time to next frame_start + 1.

Test Plan:
- DEBOUNCE_CYC=8, HOLD_CYC=40, NUM_POS=3, MIN_PW=100, STEP_PW=50; hold boton_n=0 for 20 cycles then release → exactly one step_pulse, 10 cycles after the falling edge; pos_idx stays 0 until next frame_start; one cycle after frame_start, pos_idx=1, pulse_width=150, pw_update=1.
- Bounce: toggle boton_n every 3 cycles for 30 cycles, then hold high → no step_pulse; pulse_width stays 100.
- Hold boton_n=0 for 150 cycles, no frame_start → steps at 10, 50, 90, 130 cycles; pending index 1,2,0,1. Then frame_start → pos_idx=1, pulse_width=150.
- Three steps before a frame (index wraps 0→1→2→0) → frame_start gives pulse_width unchanged at 100, pw_update=0.
- Step fires in the same cycle as frame_start → committed at that frame; next cycle pos_idx=1.
- Assert rst while in HELD with pos_idx=2 → next cycle pos_idx=0, pulse_width=100. Button still low after rst drops → new step only after a full DEBOUNCE_CYC.
